// File: rtl/regfile_2r1w_reader.sv
// 32 x 64-bit integer register file: one write port, two registered read ports, X31 reads as zero.
// Define REGFILE_BYPASS_EN to forward a same-edge write into a read of the same register.
module regfile_2r1w_reader #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_stall,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Handshake: a read is accepted on a posedge with rd_req=1 and rd_stall=0;
  // rd_valid/rd_data_* then present that result until the next non-stalled edge.
  // While rd_stall=1 the outputs are frozen and rd_req is ignored.

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic              rd_accept;
  logic              wr_active;

  assign rd_accept = rd_req && !rd_stall;
  assign wr_active = wr_en && (wr_addr != ZERO_ADDR);

  always_comb begin
    val_a = regs[rd_addr_a];
    val_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_active && (wr_addr == rd_addr_a)) val_a = wr_data;
    if (wr_active && (wr_addr == rd_addr_b)) val_b = wr_data;
`endif
    // The zero register wins over any bypass.
    if (rd_addr_a == ZERO_ADDR) val_a = '0;
    if (rd_addr_b == ZERO_ADDR) val_b = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else if (!rd_stall) begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data_a <= val_a;
        rd_data_b <= val_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_reader.sv
// Self-checking bench for regfile_2r1w_reader: directed test-plan sequences plus random traffic
// checked cycle by cycle against a register-file reference model through an expected queue.
module tb_regfile_2r1w_reader;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int EXP_W  = 1 + 2 * DATA_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic              rd_stall;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;

  regfile_2r1w_reader dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_stall  (rd_stall),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid)
  );

  // reference model: architectural registers plus the observable read outputs
  logic [DATA_W-1:0] m_regs [32];
  logic              m_valid;
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;

  logic [EXP_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [DATA_W-1:0] model_value(input int addr, input logic we,
                                                    input int wa, input logic [DATA_W-1:0] wd);
    if (addr == 31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == addr) return wd;
`endif
    return m_regs[addr];
  endfunction

  // driver: apply one cycle of inputs, advance the model, queue the expected outputs
  task automatic step(input logic rst, input logic we, input int wa, input logic [DATA_W-1:0] wd,
                      input logic rq, input logic st, input int aa, input int ab);
    reset     = rst;
    wr_en     = we;
    wr_addr   = ADDR_W'(wa);
    wr_data   = wd;
    rd_req    = rq;
    rd_stall  = st;
    rd_addr_a = ADDR_W'(aa);
    rd_addr_b = ADDR_W'(ab);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 1'b0;
      m_a = '0;
      m_b = '0;
    end else begin
      if (!st) begin
        if (rq) begin
          m_a = model_value(aa, we, wa, wd);
          m_b = model_value(ab, we, wa, wd);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (we && wa != 31) m_regs[wa] = wd;
    end
    @(posedge clk);
    #1;
    exp_q.push_back({m_valid, m_a, m_b});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({rd_valid, rd_data_a, rd_data_b} !== e) begin
        n_fails++;
        $display("FAIL rd_out @%0t: got v=%b a=%h b=%h, expected v=%b a=%h b=%h", $time,
                 rd_valid, rd_data_a, rd_data_b, e[EXP_W-1], e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    int budget;
    // reset then read X3 / X31
    step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 3, 31);
    idle();
    // basic write / read
    step(1'b0, 1'b1, 5, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 5, 5);
    // zero register ignores writes
    step(1'b0, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 31, 5);
    step(1'b0, 1'b1, 31, 64'h1234, 1'b1, 1'b0, 31, 31);
    // same-edge hazard
    step(1'b0, 1'b1, 7, 64'd10, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 7, 64'd99, 1'b1, 1'b0, 7, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 7, 7);
    // stall hold
    step(1'b0, 1'b1, 2, 64'd42, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 2, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2, 64'd50, 1'b1, 1'b1, 4, 2);
    idle();
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 2, 4);
    // reset mid-operation
    step(1'b0, 1'b1, 9, 64'd77, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 9, 9);
    step(1'b1, 1'b1, 9, 64'd5, 1'b1, 1'b0, 9, 9);
    step(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 9, 2);
    // random traffic, addresses sometimes confined to a small set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic narrow;
      int wa, aa, ab;
      narrow = ($urandom_range(0, 1) == 1);
      wa = narrow ? $urandom_range(28, 31) : $urandom_range(0, 31);
      aa = narrow ? $urandom_range(28, 31) : $urandom_range(0, 31);
      ab = narrow ? $urandom_range(28, 31) : $urandom_range(0, 31);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wa,
           {$urandom(), $urandom()}, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, aa, ab);
    end
    idle();
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
